// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq_if
// Description : Request/result bundle for the sequential binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int N_BITS = 8
);
    logic              start;
    logic [N_BITS-1:0] bin_in;
    logic              busy;
    logic              done;
    logic [3:0]        bcd2;
    logic [3:0]        bcd1;
    logic [3:0]        bcd0;

    modport master (
        output start, bin_in,
        input  busy, done, bcd2, bcd1, bcd0
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd2, bcd1, bcd0
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble converter, one bit per clock, with
//               result digits held stable until each conversion completes.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int N_BITS = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int              CW     = $clog2(N_BITS + 1);
    localparam logic [0:0]      S_IDLE = 1'b0;
    localparam logic [0:0]      S_CONV = 1'b1;
    localparam logic [CW-1:0]   C_N    = CW'(N_BITS);
    localparam logic [CW-1:0]   C_ONE  = CW'(1);

    logic [0:0]           r_state;
    logic [0:0]           w_next_state;
    logic [N_BITS-1:0]    r_bin;
    logic [11:0]          r_acc;
    logic [CW-1:0]        r_cnt;
    logic [11:0]          r_bcd;
    logic                 r_done;

    logic [11:0]          w_adj;
    logic [11+N_BITS:0]   w_shift;
    logic [11:0]          w_acc_next;
    logic [N_BITS-1:0]    w_bin_next;
    logic                 w_last;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_finish;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_nibble
            assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ?
                                      (r_acc[4*gi +: 4] + 4'd3) : r_acc[4*gi +: 4];
        end
    endgenerate

    // The adjusted accumulator and binary register shift as one vector.
    assign w_shift    = {w_adj, r_bin} << 1;
    assign w_acc_next = w_shift[N_BITS +: 12];
    assign w_bin_next = w_shift[N_BITS-1:0];
    assign w_last     = (r_cnt == C_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_CONV;
            S_CONV:  if (w_last)    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: w_accept = bus.start;
            S_CONV: begin
                w_busy   = 1'b1;
                w_finish = w_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_bin <= bus.bin_in;
                r_acc <= '0;
                r_cnt <= C_N;
            end else if (w_busy) begin
                r_acc <= w_acc_next;
                r_bin <= w_bin_next;
                r_cnt <= r_cnt - C_ONE;
            end
            // Digits change only here, so the display never sees partial sums.
            if (w_finish) begin
                r_bcd <= w_acc_next;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.bcd2 = r_bcd[11:8];
    assign bus.bcd1 = r_bcd[7:4];
    assign bus.bcd0 = r_bcd[3:0];
endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq against a decimal model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.N_BITS(8)) b8 ();
    bin2bcd_seq_if #(.N_BITS(9)) b9 ();

    bin2bcd_seq #(.N_BITS(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    bin2bcd_seq #(.N_BITS(9)) dut9 (.clk(clk), .rst(rst), .bus(b9.slave));

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [11:0] dig8();
        return {b8.bcd2, b8.bcd1, b8.bcd0};
    endfunction

    function automatic logic [11:0] dig9();
        return {b9.bcd2, b9.bcd1, b9.bcd0};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({b8.busy, b8.done, dig8()} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_n8: busy=%b done=%b digits=%h, required 0 0 000", b8.busy, b8.done, dig8());
        end
        n_tests++;
        if ({b9.busy, b9.done, dig9()} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_n9: busy=%b done=%b digits=%h, required 0 0 000", b9.busy, b9.done, dig9());
        end
        rst = 1'b0;
    endtask

    task automatic test_max();
        logic [11:0] prev;
        prev = dig8();
        b8.bin_in = 8'd255;
        b8.start  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) b8.start = 1'b0;
            n_tests++;
            if ({b8.busy, b8.done, dig8()} !== {2'b10, prev}) begin
                n_fail++;
                $display("FAIL max_busy[%0d]: busy=%b done=%b digits=%h, required 1 0 %h", i, b8.busy, b8.done, dig8(), prev);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({b8.busy, b8.done, dig8()} !== {2'b01, 12'h255}) begin
            n_fail++;
            $display("FAIL max_done: busy=%b done=%b digits=%h, required 0 1 255", b8.busy, b8.done, dig8());
        end
        @(negedge clk);
        n_tests++;
        if (b8.done !== 1'b0) begin
            n_fail++;
            $display("FAIL max_pulse: done=%b, required 0 one cycle later", b8.done);
        end
    endtask

    task automatic test_patterns();
        int vals[8];
        logic [11:0] prev;
        vals = '{0, 99, 100, 0, 0, 0, 0, 0};
        for (int k = 3; k < 8; k++) vals[k] = int'($urandom_range(255));
        for (int k = 0; k < 8; k++) begin
            prev = dig8();
            @(negedge clk);
            b8.bin_in = 8'(vals[k]);
            b8.start  = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk);
                b8.start  = 1'b0;
                b8.bin_in = 8'($urandom);
                n_tests++;
                if ({b8.busy, b8.done, dig8()} !== {2'b10, prev}) begin
                    n_fail++;
                    $display("FAIL pattern_hold v=%0d c=%0d: busy=%b done=%b digits=%h, required 1 0 %h", vals[k], i, b8.busy, b8.done, dig8(), prev);
                end
            end
            @(negedge clk);
            n_tests++;
            if ({b8.busy, b8.done, dig8()} !== {2'b01, ref_bcd(vals[k])}) begin
                n_fail++;
                $display("FAIL pattern_result v=%0d: busy=%b done=%b digits=%h, required 0 1 %h", vals[k], b8.busy, b8.done, dig8(), ref_bcd(vals[k]));
            end
        end
    endtask

    task automatic test_ignore_start();
        int n_done = 0, n_busy = 0, done_at = 0;
        logic [11:0] res = '0;
        @(negedge clk);
        b8.bin_in = 8'd37;
        b8.start  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) b8.start = 1'b0;
            if (i == 3) begin
                b8.start  = 1'b1;
                b8.bin_in = 8'd200;
            end
            if (i == 4) begin
                b8.start  = 1'b0;
                b8.bin_in = 8'($urandom);
            end
            if (b8.busy) n_busy++;
            if (b8.done) begin
                n_done++;
                done_at = i;
                res     = dig8();
            end
        end
        n_tests++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL ignore_ndone: %0d done pulses, required 1", n_done);
        end
        n_tests++;
        if (done_at !== 9) begin
            n_fail++;
            $display("FAIL ignore_latency: done at cycle %0d, required 9", done_at);
        end
        n_tests++;
        if (n_busy !== 8) begin
            n_fail++;
            $display("FAIL ignore_busy: %0d busy cycles, required 8", n_busy);
        end
        n_tests++;
        if (res !== 12'h037) begin
            n_fail++;
            $display("FAIL ignore_result: digits=%h, required 037", res);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] prev;
        logic [11:0] d;
        prev = dig8();
        @(negedge clk);
        b8.bin_in = 8'd0;
        b8.start  = 1'b1;
        for (int v = 0; v < 256; v++) begin
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk);
                b8.bin_in = 8'($urandom);
                n_tests++;
                if ({b8.busy, b8.done, dig8()} !== {2'b10, prev}) begin
                    n_fail++;
                    $display("FAIL b2b_hold v=%0d c=%0d: busy=%b done=%b digits=%h, required 1 0 %h", v, i, b8.busy, b8.done, dig8(), prev);
                end
            end
            @(negedge clk);
            d = dig8();
            n_tests++;
            if ({b8.busy, b8.done, d} !== {2'b01, ref_bcd(v)}) begin
                n_fail++;
                $display("FAIL b2b_result v=%0d: busy=%b done=%b digits=%h, required 0 1 %h", v, b8.busy, b8.done, d, ref_bcd(v));
            end
            n_tests++;
            if (d[11:8] > 4'd9 || d[7:4] > 4'd9 || d[3:0] > 4'd9) begin
                n_fail++;
                $display("FAIL b2b_digit_range v=%0d: digits=%h, required each <= 9", v, d);
            end
            prev = ref_bcd(v);
            if (v < 255) b8.bin_in = 8'(v + 1);
            else         b8.start  = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        b8.bin_in = 8'd123;
        b8.start  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            b8.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({b8.busy, b8.done, dig8()} !== 14'h0) begin
            n_fail++;
            $display("FAIL midreset_state: busy=%b done=%b digits=%h, required 0 0 000", b8.busy, b8.done, dig8());
        end
        b8.bin_in = 8'd123;
        b8.start  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            b8.start  = 1'b0;
            b8.bin_in = 8'($urandom);
            n_tests++;
            if ({b8.busy, b8.done, dig8()} !== 14'h2000) begin
                n_fail++;
                $display("FAIL midreset_restart c=%0d: busy=%b done=%b digits=%h, required 1 0 000", i, b8.busy, b8.done, dig8());
            end
        end
        @(negedge clk);
        n_tests++;
        if ({b8.busy, b8.done, dig8()} !== {2'b01, 12'h123}) begin
            n_fail++;
            $display("FAIL midreset_result: busy=%b done=%b digits=%h, required 0 1 123", b8.busy, b8.done, dig8());
        end
    endtask

    task automatic test_n9();
        int vals[5];
        logic [11:0] prev;
        vals = '{511, 0, 256, 0, 0};
        vals[3] = int'($urandom_range(511));
        vals[4] = int'($urandom_range(511));
        for (int k = 0; k < 5; k++) begin
            prev = dig9();
            @(negedge clk);
            b9.bin_in = 9'(vals[k]);
            b9.start  = 1'b1;
            for (int i = 1; i <= 9; i++) begin
                @(negedge clk);
                b9.start  = 1'b0;
                b9.bin_in = 9'($urandom);
                n_tests++;
                if ({b9.busy, b9.done, dig9()} !== {2'b10, prev}) begin
                    n_fail++;
                    $display("FAIL n9_hold v=%0d c=%0d: busy=%b done=%b digits=%h, required 1 0 %h", vals[k], i, b9.busy, b9.done, dig9(), prev);
                end
            end
            @(negedge clk);
            n_tests++;
            if ({b9.busy, b9.done, dig9()} !== {2'b01, ref_bcd(vals[k])}) begin
                n_fail++;
                $display("FAIL n9_result v=%0d: busy=%b done=%b digits=%h, required 0 1 %h", vals[k], b9.busy, b9.done, dig9(), ref_bcd(vals[k]));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b8.start  = 1'b0;
        b8.bin_in = '0;
        b9.start  = 1'b0;
        b9.bin_in = '0;
        test_reset();
        test_max();
        test_patterns();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_n9();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter N_BITS, default 8: width of the binary input. Legal range is 1..9, which keeps the result at or below 511 so that three BCD digits always suffice.
REQ-002 Port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port start, input, 1: request to convert bin_in; sampled only while idle.
REQ-005 Port bin_in, input, N_BITS: unsigned binary value, captured on the accepting edge.
REQ-006 Port busy, output, 1: high while a conversion is in progress.
REQ-007 Port done, output, 1: one-cycle pulse marking new result digits.
REQ-008 Port bcd2, output, 4: hundreds digit; drives a 7-segment decoder directly.
REQ-009 Port bcd1, output, 4: tens digit.
REQ-010 Port bcd0, output, 4: ones digit.

Function
REQ-011 The block SHALL implement sequential shift-add-3 (double dabble) conversion with exactly two states, IDLE and CONV.
REQ-012 In IDLE, start=1 at a rising edge SHALL:
- capture bin_in into an internal shift register;
- clear the internal 12-bit BCD accumulator;
- load an iteration counter with N_BITS;
- enter CONV and set busy=1.
REQ-013 Each CONV cycle SHALL do the following, in order:
- add 3 to every accumulator nibble that is 5 or greater;
- shift {accumulator, binary register} left by one;
- decrement the counter.
REQ-014 On the edge that completes the N_BITS-th iteration, the block SHALL:
- load bcd2, bcd1 and bcd0 from the final accumulator;
- set done=1 and busy=0;
- return to IDLE.
REQ-015 Latency SHALL be fixed: start accepted at edge k gives done=1 during the cycle after edge k+N_BITS. busy SHALL be high for exactly N_BITS cycles.
REQ-016 bcd2, bcd1 and bcd0 SHALL hold the previous result for the whole of CONV and change only on the completion edge, so the display never shows intermediate values.
REQ-017 done SHALL stay high for exactly one cycle per conversion and SHALL never be high together with busy.
REQ-018 start while in CONV SHALL be ignored: no restart, no queuing, and bin_in is not resampled.
REQ-019 start during the done cycle SHALL be accepted, since the block is then in IDLE; back-to-back conversions repeat every N_BITS+1 cycles.
REQ-020 start held high continuously SHALL produce back-to-back conversions, each capturing the bin_in present on its own accepting edge.
REQ-021 Every output digit SHALL always be in the range 0..9, because the downstream decoder is defined only for codes 0..9.
REQ-022 For N_BITS of 6 or less, bcd2 SHALL always be 0.
REQ-023 Changes on bin_in outside the accepting edge SHALL have no effect.

Reset
REQ-024 When rst=1 at a rising edge, the block SHALL:
- enter IDLE;
- set busy=0 and done=0;
- set bcd2, bcd1 and bcd0 to 0;
- clear the accumulator, binary register and counter.
REQ-025 rst SHALL take priority over start and over any in-progress conversion. A conversion interrupted by reset SHALL produce no done pulse and no output update.
REQ-026 After rst is released, the block SHALL accept start on the very next edge.

Verification
REQ-027 With N_BITS=8: bin_in=255 and a one-cycle start -> busy for 8 cycles, then done pulse with bcd2=2, bcd1=5, bcd0=5.
REQ-028 bin_in=0 -> 0,0,0 with done. Then bin_in=99 -> 0,9,9. Then bin_in=100 -> 1,0,0. Outputs stay unchanged during each busy window.
REQ-029 Start with bin_in=37, then pulse start again at busy cycle 3 with bin_in=200 -> only one done, result 0,3,7. The second request is dropped.
REQ-030 Hold start=1 while stepping bin_in through 0..255 on each accepting edge -> one done every 9 cycles, every result matches the decimal reference model, and no digit exceeds 9.
REQ-031 Start with bin_in=123, assert rst at busy cycle 4 -> no done pulse, all digits 0, busy=0. A new start then yields 1,2,3.
REQ-032 With N_BITS=9: bin_in=511 -> 5,1,1 after 9 busy cycles.
